// File: rtl/xadc_sample_avg.sv
// XADC DRP reader with boxcar averaging of 2^AVG_LOG2 results and a
// valid/ready output register carrying each completed average.
module xadc_sample_avg #(
  parameter logic [4:0]  CHANNEL     = 5'h03,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned DRP_TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  output logic        den_out,
  output logic [6:0]  daddr_out,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic [11:0] sample_out,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned ACC_W  = 12 + AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam int unsigned TCNT_W = (DRP_TIMEOUT < 1) ? 1 : $clog2(DRP_TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_RDY} state_t;

  state_t              state, state_nxt;
  logic                trigger, take, abandon;
  logic [TCNT_W-1:0]   tcnt;
  logic [ACC_W-1:0]    acc, sum, avg_full;
  logic [CNT_W-1:0]    count;
  logic                last, new_result;
  logic                unused_bits;

  assign daddr_out   = {2'b00, CHANNEL};
  assign unused_bits = ^do_in[3:0];

  assign sum        = acc + ACC_W'(do_in[15:4]);
  assign avg_full   = sum >> AVG_LOG2;
  assign last       = (count == CNT_W'((1 << AVG_LOG2) - 1));
  assign new_result = take && last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    trigger   = 1'b0;
    take      = 1'b0;
    abandon   = 1'b0;
    case (state)
      IDLE: begin
        if (eoc_in && (channel_in == CHANNEL)) begin
          trigger   = 1'b1;
          state_nxt = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (drdy_in) begin
          take      = 1'b1;
          state_nxt = IDLE;
        end else if (tcnt == TCNT_W'(DRP_TIMEOUT)) begin
          abandon   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      den_out      <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
      tcnt         <= '0;
      acc          <= '0;
      count        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      den_out     <= trigger;
      timeout_err <= abandon;
      overrun     <= new_result && sample_valid && !sample_ready;

      if (trigger)
        tcnt <= '0;
      else if ((state == WAIT_RDY) && !drdy_in && !abandon)
        tcnt <= tcnt + TCNT_W'(1);

      if (take) begin
        if (last) begin
          acc   <= '0;
          count <= '0;
        end else begin
          acc   <= sum;
          count <= count + CNT_W'(1);
        end
      end

      // Output register runs independently of the FSM; a new average always wins
      if (new_result) begin
        sample_out   <= avg_full[11:0];
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xadc_sample_avg.sv
// Bench for xadc_sample_avg: a pass-through and a 4-sample instance share stimulus
// and are checked every cycle against a sample-history reference model.
module tb_xadc_sample_avg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        eoc_in = 1'b0;
  logic [4:0]  channel_in = '0;
  logic        drdy_in = 1'b0;
  logic [15:0] do_in = '0;
  logic        sample_ready = 1'b0;

  logic        den [2];
  logic [6:0]  daddr [2];
  logic [11:0] s_out [2];
  logic        s_valid [2];
  logic        s_ovr [2];
  logic        s_tmo [2];

  always #5 clk = ~clk;

  xadc_sample_avg #(.CHANNEL(5'h03), .AVG_LOG2(0), .DRP_TIMEOUT(31)) u_pass (
    .clk(clk), .rst(rst), .eoc_in(eoc_in), .channel_in(channel_in),
    .den_out(den[0]), .daddr_out(daddr[0]), .drdy_in(drdy_in), .do_in(do_in),
    .sample_out(s_out[0]), .sample_valid(s_valid[0]), .sample_ready(sample_ready),
    .overrun(s_ovr[0]), .timeout_err(s_tmo[0])
  );

  xadc_sample_avg #(.CHANNEL(5'h03), .AVG_LOG2(2), .DRP_TIMEOUT(31)) u_avg (
    .clk(clk), .rst(rst), .eoc_in(eoc_in), .channel_in(channel_in),
    .den_out(den[1]), .daddr_out(daddr[1]), .drdy_in(drdy_in), .do_in(do_in),
    .sample_out(s_out[1]), .sample_valid(s_valid[1]), .sample_ready(sample_ready),
    .overrun(s_ovr[1]), .timeout_err(s_tmo[1])
  );

  int errors = 0;
  int checks = 0;

  bit          exp_den = 1'b0;
  bit          exp_tmo = 1'b0;
  bit          exp_valid [2] = '{1'b0, 1'b0};
  bit          exp_ovr [2]   = '{1'b0, 1'b0};
  logic [11:0] exp_out [2]   = '{12'h000, 12'h000};
  bit          pend_new [2]  = '{1'b0, 1'b0};
  logic [11:0] pend_avg [2]  = '{12'h000, 12'h000};
  bit          rnd_ready = 1'b0;

  int unsigned hist [$];
  int unsigned base [2] = '{0, 0};

  function automatic int unsigned nlog(input int unsigned i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("den[%0d]", i),   16'(den[i]),     16'(exp_den));
      chk($sformatf("daddr[%0d]", i), 16'(daddr[i]),   16'h0003);
      chk($sformatf("tmo[%0d]", i),   16'(s_tmo[i]),   16'(exp_tmo));
      chk($sformatf("valid[%0d]", i), 16'(s_valid[i]), 16'(exp_valid[i]));
      chk($sformatf("out[%0d]", i),   16'(s_out[i]),   16'(exp_out[i]));
      chk($sformatf("ovr[%0d]", i),   16'(s_ovr[i]),   16'(exp_ovr[i]));
    end
  endtask

  // Applies the handshake rules for the coming edge, then checks every output.
  task automatic step();
    if (rnd_ready) sample_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < 2; i++) begin
      exp_ovr[i] = 1'b0;
      if (pend_new[i]) begin
        if (exp_valid[i] && !sample_ready) exp_ovr[i] = 1'b1;
        exp_out[i]   = pend_avg[i];
        exp_valid[i] = 1'b1;
      end else if (exp_valid[i] && sample_ready) begin
        exp_valid[i] = 1'b0;
      end
      pend_new[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all();
    exp_den = 1'b0;
    exp_tmo = 1'b0;
  endtask

  function automatic void push_sample(input logic [15:0] d);
    int unsigned sum;
    hist.push_back(int'(d[15:4]));
    for (int i = 0; i < 2; i++) begin
      if (hist.size() - base[i] == (1 << nlog(i))) begin
        sum = 0;
        for (int k = int'(base[i]); k < hist.size(); k++) sum += hist[k];
        pend_avg[i] = 12'(sum >> nlog(i));
        pend_new[i] = 1'b1;
        base[i]     = hist.size();
      end
    end
  endfunction

  function automatic void clear_model();
    hist.delete();
    base    = '{0, 0};
    exp_den = 1'b0;
    exp_tmo = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_valid[i] = 1'b0;
      exp_ovr[i]   = 1'b0;
      exp_out[i]   = 12'h000;
      pend_new[i]  = 1'b0;
    end
  endfunction

  task automatic reset_dut();
    rst = 1'b0;
    #1;
    clear_model();
    check_all();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic start_read();
    eoc_in     = 1'b1;
    channel_in = 5'd3;
    exp_den    = 1'b1;
    step();
    eoc_in = 1'b0;
  endtask

  task automatic finish_read(input logic [15:0] d);
    drdy_in = 1'b1;
    do_in   = d;
    push_sample(d);
    step();
    drdy_in = 1'b0;
    do_in   = 16'($urandom);
  endtask

  task automatic read(input logic [15:0] d, input int unsigned lat);
    start_read();
    repeat (lat) step();
    finish_read(d);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    step();

    // pass-through: drdy 4 cycles after den
    sample_ready = 1'b1;
    read(16'hABC0, 4);
    chk("pass_out", 16'(s_out[0]), 16'h0ABC);
    chk("pass_valid", 16'(s_valid[0]), 16'h0001);
    step();
    chk("pass_cleared", 16'(s_valid[0]), 16'h0000);

    // averaging with truncation: 1031 >> 2
    reset_dut();
    read(16'h1000, 1);
    read(16'h1010, 3);
    read(16'h1020, 2);
    chk("avg_none_yet", 16'(s_valid[1]), 16'h0000);
    read(16'h1040, 5);
    chk("avg_result", 16'(s_out[1]), 16'h0101);
    step();

    // channel filter, busy eoc, idle drdy
    eoc_in = 1'b1; channel_in = 5'd5;
    step();
    eoc_in = 1'b0;
    step();
    start_read();
    step();
    eoc_in = 1'b1; channel_in = 5'd3;
    step();
    eoc_in = 1'b0;
    step();
    finish_read(16'h2220);
    step();
    drdy_in = 1'b1; do_in = 16'hFFF0;
    step();
    drdy_in = 1'b0;
    step();

    // backpressure: overwrite, then new result coincident with ready
    reset_dut();
    sample_ready = 1'b0;
    read(16'h0100, 2);
    read(16'h0200, 2);
    chk("bp_overwrite", 16'(s_out[0]), 16'h0020);
    repeat (3) step();
    start_read();
    repeat (2) step();
    sample_ready = 1'b1;
    finish_read(16'h0300);
    chk("bp_loaded", 16'(s_out[0]), 16'h0030);
    step();

    // timeout preserves the partial average
    reset_dut();
    read(16'h0010, 1);
    read(16'h0020, 2);
    start_read();
    repeat (31) step();
    exp_tmo = 1'b1;
    step();
    step();
    drdy_in = 1'b1; do_in = 16'h7770;
    step();
    drdy_in = 1'b0;
    read(16'h0030, 3);
    read(16'h0040, 1);
    chk("tmo_avg", 16'(s_out[1]), 16'h0002);
    step();

    // reset mid-read with two samples accumulated, then a late drdy
    reset_dut();
    read(16'h0500, 1);
    read(16'h0600, 1);
    start_read();
    repeat (2) step();
    rst = 1'b0;
    #1;
    clear_model();
    check_all();
    step();
    rst = 1'b1;
    step();
    drdy_in = 1'b1; do_in = 16'h0FF0;
    step();
    drdy_in = 1'b0;
    step();
    read(16'h0040, 2);
    read(16'h0080, 2);
    read(16'h00C0, 2);
    chk("rst_fresh_none", 16'(s_valid[1]), 16'h0000);
    read(16'h0100, 2);
    chk("rst_fresh_avg", 16'(s_out[1]), 16'h000A);
    step();

    // randomized reads with random consumer backpressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) step();
      read(16'($urandom), $urandom_range(1, 10));
    end
    rnd_ready = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
